// File: rtl/cafe_pkg.sv
// ============================================================================
// cafe_pkg : shared state type, drink codes and dose table for the sequencer
// Revision : 1.0
// ============================================================================
`default_nettype none

package cafe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CAFE  = 3'd1,
        ST_LECHE = 3'd2,
        ST_DONE  = 3'd3
    } estado_t;

    localparam logic [1:0] ESPRESSO  = 2'd0;
    localparam logic [1:0] AMERICANO = 2'd1;
    localparam logic [1:0] CORTADO   = 2'd2;
    localparam logic [1:0] LATTE     = 2'd3;

    localparam int TIMEOUT_CYC_DEFAULT = 8;

    typedef struct packed {
        logic [1:0] cafe;
        logic [1:0] leche;
    } dosis_t;

    function automatic dosis_t dosis_de(input logic [1:0] bebida);
        dosis_t d;
        case (bebida)
            ESPRESSO:  d = '{cafe: 2'd1, leche: 2'd0};
            AMERICANO: d = '{cafe: 2'd2, leche: 2'd0};
            CORTADO:   d = '{cafe: 2'd1, leche: 2'd1};
            default:   d = '{cafe: 2'd1, leche: 2'd2};
        endcase
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stage_timer.sv
// ============================================================================
// stage_timer : saturating phase timer, shared by the coffee and milk phases
// Revision    : 1.0
// ============================================================================
`default_nettype none

module stage_timer #(
    parameter int TW    = 4,
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TW-1:0] C_MAX  = '1;
    localparam logic [TW-1:0] C_LAST = TW'(LIMIT - 1);

    logic [TW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && (r_count != C_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Flags the last allowed cycle, so the counter would reach LIMIT on the
    // same edge the phase is abandoned: the enable stays up exactly LIMIT cycles.
    assign expired = en && (r_count >= C_LAST);

endmodule

`default_nettype wire

// File: rtl/drink_sequencer.sv
// ============================================================================
// drink_sequencer : turns one drink order into the coffee -> milk enable sequence
// Revision        : 1.0
// ============================================================================
`default_nettype none

module drink_sequencer
    import cafe_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
    parameter int TW          = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] bebida_sel,
    input  logic       cancel,
    input  logic       cafe_done,
    input  logic       leche_done,
    output logic       enable_cafe,
    output logic [1:0] dosis_cafe,
    output logic       enable_leche,
    output logic [1:0] dosis_leche,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] estado
);

    estado_t    r_state;
    estado_t    w_next;
    logic [1:0] r_dose_cafe;
    logic [1:0] r_dose_leche;
    logic [1:0] w_dose_cafe;
    logic [1:0] w_dose_leche;
    logic       w_error;
    logic       w_running;
    logic       w_expired;
    dosis_t     w_tbl;

    assign w_tbl     = dosis_de(bebida_sel);
    assign w_running = (r_state == ST_CAFE) || (r_state == ST_LECHE);

    stage_timer #(
        .TW    (TW),
        .LIMIT (TIMEOUT_CYC)
    ) u_stage_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_next != r_state),
        .en      (w_running),
        .expired (w_expired)
    );

    always_comb begin
        w_next       = r_state;
        w_error      = error;
        w_dose_cafe  = r_dose_cafe;
        w_dose_leche = r_dose_leche;
        case (r_state)
            ST_IDLE: begin
                if (start && !cancel) begin
                    w_next       = ST_CAFE;
                    w_error      = 1'b0;
                    w_dose_cafe  = w_tbl.cafe;
                    w_dose_leche = w_tbl.leche;
                end
            end
            // Priority inside a phase: cancel, then completion, then timeout.
            ST_CAFE: begin
                if (cancel) begin
                    w_next = ST_IDLE;
                end else if (cafe_done) begin
                    w_next = (r_dose_leche == 2'd0) ? ST_DONE : ST_LECHE;
                end else if (w_expired) begin
                    w_next  = ST_IDLE;
                    w_error = 1'b1;
                end
            end
            ST_LECHE: begin
                if (cancel) begin
                    w_next = ST_IDLE;
                end else if (leche_done) begin
                    w_next = ST_DONE;
                end else if (w_expired) begin
                    w_next  = ST_IDLE;
                    w_error = 1'b1;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_dose_cafe  <= 2'd0;
            r_dose_leche <= 2'd0;
            enable_cafe  <= 1'b0;
            dosis_cafe   <= 2'd0;
            enable_leche <= 1'b0;
            dosis_leche  <= 2'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            estado       <= 3'd0;
        end else begin
            r_state      <= w_next;
            r_dose_cafe  <= w_dose_cafe;
            r_dose_leche <= w_dose_leche;
            enable_cafe  <= (w_next == ST_CAFE);
            dosis_cafe   <= (w_next == ST_CAFE) ? w_dose_cafe : 2'd0;
            enable_leche <= (w_next == ST_LECHE);
            dosis_leche  <= (w_next == ST_LECHE) ? w_dose_leche : 2'd0;
            busy         <= (w_next != ST_IDLE);
            done         <= (w_next == ST_DONE);
            error        <= w_error;
            estado       <= w_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_drink_sequencer.sv
// ============================================================================
// tb_drink_sequencer : directed vector bench for drink_sequencer
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_drink_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] bebida_sel;
    logic       cancel;
    logic       cafe_done;
    logic       leche_done;
    logic       enable_cafe;
    logic [1:0] dosis_cafe;
    logic       enable_leche;
    logic [1:0] dosis_leche;
    logic       busy;
    logic       done;
    logic       error;
    logic [2:0] estado;

    always #5 clk = ~clk;

    drink_sequencer #(
        .TIMEOUT_CYC (8),
        .TW          (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .bebida_sel   (bebida_sel),
        .cancel       (cancel),
        .cafe_done    (cafe_done),
        .leche_done   (leche_done),
        .enable_cafe  (enable_cafe),
        .dosis_cafe   (dosis_cafe),
        .enable_leche (enable_leche),
        .dosis_leche  (dosis_leche),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .estado       (estado)
    );

    // Expected/observed output word: {en_cafe, dosis_cafe, en_leche, dosis_leche, busy, done, error, estado}
    typedef struct {
        string      name;
        logic       s;
        logic [1:0] sel;
        logic       cn;
        logic       cd;
        logic       ld;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [11:0] outs();
        return {enable_cafe, dosis_cafe, enable_leche, dosis_leche, busy, done, error, estado};
    endfunction

    task automatic check(input string nm, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", nm, got, exp);
        end
    endtask

    task automatic add(input string nm, input logic s, input logic [1:0] sel,
                       input logic cn, input logic cd, input logic ld,
                       input logic ec, input logic [1:0] dc, input logic el,
                       input logic [1:0] dl, input logic b, input logic d,
                       input logic e, input logic [2:0] st);
        vec_t v;
        v.name = nm; v.s = s; v.sel = sel; v.cn = cn; v.cd = cd; v.ld = ld;
        v.exp  = {ec, dc, el, dl, b, d, e, st};
        vecs.push_back(v);
    endtask

    task automatic add_idle(input string nm, input logic e);
        add(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e, 0);
    endtask

    // A CAFE cycle with dose dc and no inputs active
    task automatic add_cafe(input string nm, input logic [1:0] dc, input logic e);
        add(nm, 0, 0, 0, 0, 0, 1, dc, 0, 0, 1, 0, e, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; bebida_sel = 2'd0;
        cancel = 1'b0; cafe_done = 1'b0; leche_done = 1'b0;

        // latte
        add("latte_start",      1, 3, 0, 0, 0,  1, 1, 0, 0, 1, 0, 0, 1);
        add_cafe("latte_cafe1", 1, 0);
        add_cafe("latte_cafe2", 1, 0);
        add("latte_cafe_done",  0, 0, 0, 1, 0,  0, 0, 1, 2, 1, 0, 0, 2);
        add("latte_leche_done", 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 1, 0, 3);
        add_idle("latte_idle1", 0);
        add_idle("latte_idle2", 0);
        // americano, with a start pulse during CAFE that must be ignored
        add("amer_start",       1, 1, 0, 0, 0,  1, 2, 0, 0, 1, 0, 0, 1);
        add("amer_start_ign",   1, 3, 0, 0, 0,  1, 2, 0, 0, 1, 0, 0, 1);
        add("amer_cafe_done",   0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 1, 0, 3);
        add_idle("amer_idle", 0);
        add("start_with_cancel",1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        add_idle("after_start_cancel", 0);
        // cortado timeout: 8 CAFE cycles, then back to IDLE with error
        add("to_start",         1, 2, 0, 0, 0,  1, 1, 0, 0, 1, 0, 0, 1);
        for (int i = 1; i < 8; i++) add_cafe($sformatf("to_cafe%0d", i), 1, 0);
        add("to_expire",        0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
        add_idle("to_idle", 1);
        add("to_start_clears",  1, 2, 0, 0, 0,  1, 1, 0, 0, 1, 0, 0, 1);
        add("cort_cafe_done",   0, 0, 0, 1, 0,  0, 0, 1, 1, 1, 0, 0, 2);
        add("cancel_with_done", 0, 0, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
        add_idle("cancel_idle", 0);
        // plain cancel in LECHE
        add("l2_start",         1, 3, 0, 0, 0,  1, 1, 0, 0, 1, 0, 0, 1);
        add("l2_cafe_done",     0, 0, 0, 1, 0,  0, 0, 1, 2, 1, 0, 0, 2);
        add("l2_leche_hold",    0, 0, 0, 0, 0,  0, 0, 1, 2, 1, 0, 0, 2);
        add("l2_cancel",        0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        add_idle("l2_idle", 0);
        // stale cafe_done already high when enable rises
        add("stale_start",      1, 0, 0, 1, 0,  1, 1, 0, 0, 1, 0, 0, 1);
        add("stale_done",       0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 1, 0, 3);
        add_idle("stale_idle", 0);
        // done arriving on the last allowed cycle beats the timeout
        add("dvt_start",        1, 0, 0, 0, 0,  1, 1, 0, 0, 1, 0, 0, 1);
        for (int i = 1; i < 8; i++) add_cafe($sformatf("dvt_cafe%0d", i), 1, 0);
        add("dvt_done",         0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 1, 0, 3);
        add_idle("dvt_idle", 0);
        // cancel on the last allowed cycle beats both done and timeout
        add("cvt_start",        1, 1, 0, 0, 0,  1, 2, 0, 0, 1, 0, 0, 1);
        for (int i = 1; i < 8; i++) add_cafe($sformatf("cvt_cafe%0d", i), 2, 0);
        add("cvt_cancel",       0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        add_idle("cvt_idle", 0);

        repeat (2) @(negedge clk);
        check("reset_state", outs(), 12'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            start      = vecs[i].s;
            bebida_sel = vecs[i].sel;
            cancel     = vecs[i].cn;
            cafe_done  = vecs[i].cd;
            leche_done = vecs[i].ld;
            @(negedge clk);
            check(vecs[i].name, outs(), vecs[i].exp);
        end

        // asynchronous reset in the middle of a CAFE phase
        start = 1'b1; bebida_sel = 2'd3; cancel = 1'b0; cafe_done = 1'b0; leche_done = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("async_pre_cafe", outs(), {1'b1, 2'd1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd1});
        #2 rst_n = 1'b0;
        #1 check("async_reset_flush", outs(), 12'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("async_post_idle", outs(), 12'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/drink_sequencer.md
Name: drink_sequencer

Overview:
- Master controller for the beverage machine. It turns one user order into the ordered enable sequence for the dispenser stages: coffee first, then milk.
- It is the initiator side of the stage enable/done handshake. It raises a stage enable, holds it, and waits for that stage's completion flag.
- It sits between the user-input/debounce logic and the coffee and milk dispenser blocks. It reports busy, done and error to the LED/display logic.

Parameters:
- TIMEOUT_CYC, 8, maximum cycles a stage may hold its enable without reporting done (1 Hz clk, so this is seconds)
- TW, 4, width of the timeout counter; must satisfy 2**TW > TIMEOUT_CYC

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  order request, one-cycle pulse, sampled only in IDLE
- bebida_sel  in  2  drink code: 0 espresso, 1 americano, 2 cortado, 3 latte
- cancel  in  1  abort the current order; level, sampled every cycle
- cafe_done  in  1  completion flag from the coffee stage; level, held until its enable drops
- leche_done  in  1  completion flag from the milk stage; same rules as cafe_done
- enable_cafe  out  1  coffee stage enable; held high for the whole coffee phase
- dosis_cafe  out  2  coffee dose count to the coffee stage; valid while enable_cafe=1
- enable_leche  out  1  milk stage enable
- dosis_leche  out  2  milk dose count; valid while enable_leche=1
- busy  out  1  high in CAFE, LECHE and DONE
- done  out  1  one-cycle pulse when an order completes
- error  out  1  sticky timeout flag; cleared by the next accepted start or by reset
- estado  out  3  current state encoding, for the display

Behaviour:
- Reset (asynchronous, rst_n=0) forces the following; all are registered outputs:
  - state = IDLE
  - all outputs = 0
  - timeout counter = 0
  - latched doses = 0
- Drink table (doses, coffee/milk):
  - espresso 1/0
  - americano 2/0
  - cortado 1/1
  - latte 1/2
- IDLE:
  - On start=1 and cancel=0, latch the bebida_sel doses and clear error.
  - Next cycle: state=CAFE, enable_cafe=1, dosis_cafe = latched dose.
  - start together with cancel is ignored.
  - start outside IDLE is ignored; no queueing.
- CAFE:
  - enable_cafe stays 1 and the timeout counter increments every cycle.
  - When cafe_done=1:
    - drop enable_cafe and clear the counter;
    - if the milk dose is 0, go to DONE;
    - otherwise go to LECHE with enable_leche=1, dosis_leche = latched dose.
  - There are no overlap cycles: enable_cafe and enable_leche are never both 1.
- LECHE:
  - Same rules as CAFE, using leche_done.
  - When leche_done=1, go to DONE.
- DONE:
  - Lasts exactly 1 cycle: done=1, busy=1.
  - Then go to IDLE; busy falls the following cycle.
- Timeout:
  - If the counter reaches TIMEOUT_CYC in CAFE or LECHE with no done flag, set error=1.
  - Drop all enables, clear the counter, go to IDLE with no done pulse.
  - If the done flag and the timeout land in the same cycle, done wins.
- Cancel:
  - cancel=1 in CAFE or LECHE drops the enables the next cycle and returns to IDLE.
  - No done pulse; error is unchanged.
  - Cancel beats both a done flag and a timeout in the same cycle.
- Stale done flag: a done input already high when its enable rises is treated as valid completion, so the phase lasts 1 cycle. The stage blocks own clearing their flags.
- Latency: start to enable_cafe is 1 cycle; a done flag to the next enable or to done is 1 cycle.
- estado encoding: IDLE=0, CAFE=1, LECHE=2, DONE=3.
- Counter width: TW bits, saturating; it never wraps.

Decomposition:
- Package cafe_pkg holds:
  - the state enum type (estado_t);
  - drink code constants (ESPRESSO, AMERICANO, CORTADO, LATTE);
  - the dose table as a constant function dosis_de(bebida) returning {cafe, leche};
  - the default TIMEOUT_CYC value.
- Sub-module stage_timer: TW-bit saturating counter with clear and an expired flag, instantiated once and shared by both phases.
- Everything else stays in a single FSM module.

Test Plan:
- Reset, then latte: start, sel=3.
  - Next cycle: enable_cafe=1, dosis_cafe=1.
  - Assert cafe_done after 3 cycles: next cycle enable_cafe=0, enable_leche=1, dosis_leche=2.
  - Assert leche_done: next cycle done=1 for exactly 1 cycle, then estado=0.
- Americano: start, sel=1 gives dosis_cafe=2. Asserting cafe_done goes straight to DONE; enable_leche never rises.
- Timeout: cortado with cafe_done held 0.
  - After 8 cycles in CAFE: error=1, enables=0, estado=0, no done pulse.
  - The next start clears error.
- Cancel in LECHE: cancel=1 drops enable_leche and returns to IDLE next cycle, with no done pulse. Also assert cancel together with leche_done in one cycle: still no done pulse.
- Async reset mid-CAFE: rst_n low between clock edges clears enable_cafe and estado immediately, without waiting for a clock edge.
- Ignored inputs:
  - start pulses during CAFE are ignored and the doses are unchanged;
  - start together with cancel in IDLE leaves busy=0.
